stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
Parametrised N-to-1 selector for WIDTH-bit data words (default 128-bit AES blocks), with valid/ready handshaking on every channel and one registered output stage. Supports a fixed-select mode (software-chosen channel) and a round-robin mode (fair sharing between cores). Sits between parallel block producers and a single downstream consumer.

Parameters:
WIDTH, 128, data word width in bits
NUM_CH, 4, number of input channels (>=2, need not be a power of two)
SEL_W, $clog2(NUM_CH), derived localparam; width of sel and out_ch

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  NUM_CH*WIDTH  packed channel words; channel i at [i*WIDTH +: WIDTH]
in_valid  input  NUM_CH  per-channel word valid
in_ready  output  NUM_CH  per-channel accept; at most one bit set
sel  input  SEL_W  channel chosen in fixed mode
rr_en  input  1  1 = round-robin mode, 0 = fixed-select mode
out_data  output  WIDTH  registered selected word
out_valid  output  1  out_data holds a word
out_ready  input  1  downstream accept
out_ch  output  SEL_W  source channel index of out_data

Behaviour:
- Reset (async assert, sync-safe deassert): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=NUM_CH-1, so the first round-robin search starts at ch0.
- Output stage states: EMPTY (out_valid=0) and FULL (out_valid=1). load_ok = !out_valid || out_ready (combinational).
- Fixed mode: grant g=sel if sel<NUM_CH and in_valid[sel]. No grant otherwise, including sel>=NUM_CH. ptr is not updated.
- Round-robin mode: g is the first i with in_valid[i], searching ptr+1, ptr+2, ... cyclically mod NUM_CH. No grant if in_valid==0.
- in_ready[g] = load_ok && grant. All other in_ready bits are 0. in_ready is combinational from out_ready/in_valid/sel/rr_en/ptr; it has no registered dependence on itself.
- Transfer on channel g (in_valid[g] && in_ready[g]):
  - next edge: out_data<=word g, out_ch<=g, out_valid<=1.
  - if rr_en, ptr<=g.
- load_ok with no grant: out_valid<=0, and out_data/out_ch hold.
- Stall (out_valid && !out_ready): out_data, out_ch and out_valid are held stable, and all in_ready are 0.
- Latency: 1 cycle from input handshake to out_valid. Throughput: 1 word/cycle when out_ready is held high.
- Simultaneous drain and load in the same cycle: out_valid stays 1 and the new word replaces the old one with no bubble.
- Mode or sel change mid-stream: takes effect in the same cycle's arbitration and never corrupts a held output word.
- Reset mid-transfer: the output word is discarded and out_valid drops immediately (async).
- Input words must stay stable while in_valid=1 and not accepted. The block does not check this.

Decomposition:
- Shared package stream_mux_pkg: default WIDTH/NUM_CH constants, and function rr_pick(valid, ptr) returning {found, index}.
- One natural sub-module, rr_arbiter (combinational): inputs valid, ptr, rr_en, sel; outputs grant_valid, grant_idx.
- Top level holds only the output register, ptr and the in_ready decode.

Test Plan:
1. Reset, then fixed mode:
   - Stimulus: in0..in3 = d3fa4672..., cd354224..., b497dd1a..., 0cc175b9..., all valid; out_ready=1; sel stepped 0,1,2,3 each cycle.
   - Required: out_data follows the selected word 1 cycle later; out_ch=0,1,2,3; in_ready one-hot on sel.
2. Round-robin, all channels valid, out_ready=1 for 8 cycles:
   - Required: out_ch sequence 0,1,2,3,0,1,2,3; out_valid continuously high.
3. Round-robin, only ch1 and ch3 valid:
   - Required: out_ch alternates 1,3,1,3; in_ready[0] and in_ready[2] never assert.
4. Backpressure: out_ready=0 for 3 cycles after a word from ch2 loads.
   - Required: out_data and out_ch=2 held; in_ready=0000; ptr unchanged.
   - Then out_ready=1: next grant is ch3.
5. Fixed mode, sel=2, in_valid[2]=0, NUM_CH=3 build with sel=3:
   - Required: no grant; out_valid drops after drain; in_ready=000.
6. Reset mid-stream: assert rst_n low asynchronously while out_valid=1.
   - Required: out_valid=0 and out_data=0 immediately; first grant after release is ch0 in round-robin mode.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants and the round-robin search helper for stream_mux_rr.
// Latency: none. This package holds types and functions only.
// Backpressure: none. The package holds no state.
package stream_mux_pkg;

  localparam int DEF_WIDTH  = 128;
  localparam int DEF_NUM_CH = 4;

  // The helper searches a fixed-size vector, which caps the channel count.
  localparam int MAX_CH = 64;
  localparam int IDX_W  = 6;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Returns the first set bit of valid at or after ptr+1, wrapping modulo num_ch.
  // The caller must keep ptr below num_ch.
  function automatic pick_t rr_pick(input logic [MAX_CH-1:0] valid,
                                    input int unsigned       ptr,
                                    input int unsigned       num_ch);
    pick_t       res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 1; k <= MAX_CH; k++) begin
      cand = ptr + k;
      // ptr < num_ch and k <= num_ch, so one subtraction is enough to wrap.
      if (cand >= num_ch) cand = cand - num_ch;
      if (k <= num_ch && !res.found && valid[cand[IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational channel picker: fixed-select or round-robin after ptr.
// Latency: 0 cycles, purely combinational.
// Backpressure: none here. The top gates the grant with output-stage space.
// Ports: valid (per-channel request), ptr (last rr winner), rr_en (mode),
//        sel (fixed channel), grant_valid/grant_idx (chosen channel).
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] valid,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              rr_en,
  input  logic [SEL_W-1:0]  sel,
  output logic              grant_valid,
  output logic [SEL_W-1:0]  grant_idx
);

  localparam int unsigned NUM_CH_U = NUM_CH;

  logic [MAX_CH-1:0] valid_ext;
  pick_t             pick;

  always_comb begin
    valid_ext             = '0;
    valid_ext[NUM_CH-1:0] = valid;
    pick        = rr_pick(valid_ext, 32'(ptr), NUM_CH_U);
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (rr_en) begin
      // The index bound is always met. It keeps an out-of-range pick from ever granting.
      grant_valid = pick.found && (32'(pick.idx) < NUM_CH_U);
      grant_idx   = pick.idx[SEL_W-1:0];
    end else if (32'(sel) < NUM_CH_U) begin
      // When NUM_CH is not a power of two, sel can name a missing channel. That case gets no grant.
      grant_valid = valid[sel];
      grant_idx   = sel;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream selector with one registered output stage.
// Latency: 1 cycle from input handshake to out_valid; 1 word/cycle sustained.
// Backpressure: while the stage is full and out_ready=0, all in_ready are 0 and the output holds.
// Ports: in_data/in_valid/in_ready (packed channels), sel/rr_en (mode),
//        out_data/out_valid/out_ready/out_ch (registered output and source index).
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int NUM_CH = DEF_NUM_CH,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    rr_en,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_ch
);

  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] ptr;
  logic             load_ok;
  logic             fire;
  logic [WIDTH-1:0] word;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arb (
    .valid       (in_valid),
    .ptr         (ptr),
    .rr_en       (rr_en),
    .sel         (sel),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // The stage can take a word when it is empty or is draining this cycle.
  assign load_ok = !out_valid || out_ready;
  // A grant implies in_valid[grant_idx], so fire is exactly the input handshake.
  assign fire    = load_ok && grant_valid;

  always_comb begin
    in_ready = '0;
    word     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        in_ready[i] = fire;
        word        = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      // Start from the last channel so that the first round-robin search begins at ch0.
      ptr       <= SEL_W'(NUM_CH - 1);
    end else if (fire) begin
      out_valid <= 1'b1;
      out_data  <= word;
      out_ch    <= grant_idx;
      if (rr_en) ptr <= grant_idx;
    end else if (load_ok) begin
      // The stage drained with nothing to replace it. Data and channel keep their last values.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: a 4-channel instance checked every cycle
// against a reference arbiter, and a 3-channel instance for the out-of-range select case.
module tb_stream_mux_rr;

  logic         clk;
  logic         rst_n;

  logic [127:0] w [4];
  logic [511:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [1:0]   sel;
  logic         rr_en;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_ch;

  logic [127:0] w3 [3];
  logic [383:0] in_data3;
  logic [2:0]   in_valid3;
  logic [2:0]   in_ready3;
  logic [1:0]   sel3;
  logic         rr_en3;
  logic [127:0] out_data3;
  logic         out_valid3;
  logic         out_ready3;
  logic [1:0]   out_ch3;

  assign in_data  = {w[3], w[2], w[1], w[0]};
  assign in_data3 = {w3[2], w3[1], w3[0]};

  stream_mux_rr #(.WIDTH(128), .NUM_CH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .rr_en     (rr_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
  );

  stream_mux_rr #(.WIDTH(128), .NUM_CH(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .sel       (sel3),
    .rr_en     (rr_en3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_ch    (out_ch3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic [1:0]   ch;
  } exp_t;

  exp_t q[$];
  int   mptr;
  int   n_checks;
  int   n_fail;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference arbitration for the 4-channel instance.
  task automatic model_grant(output logic gv, output int gi);
    gv = 1'b0;
    gi = 0;
    if (!rr_en) begin
      gv = in_valid[sel];
      gi = int'(sel);
    end else begin
      for (int k = 1; k <= 4; k++) begin
        if (!gv && in_valid[(mptr + k) % 4]) begin
          gv = 1'b1;
          gi = (mptr + k) % 4;
        end
      end
    end
  endtask

  // Each call starts at posedge+1 and ends at the next posedge+1. Checks run mid-cycle.
  task automatic cycle();
    logic       gv;
    int         gi;
    logic       load_ok;
    logic [3:0] exp_rdy;
    exp_t       e;
    #4;
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_ch", out_ch, q[0].ch);
    end
    load_ok = (q.size() == 0) || out_ready;
    model_grant(gv, gi);
    exp_rdy = (load_ok && gv) ? (4'b0001 << gi) : 4'b0000;
    chk("in_ready", in_ready, exp_rdy);
    if (q.size() != 0 && out_ready) void'(q.pop_front());
    if (load_ok && gv) begin
      e.d  = w[gi];
      e.ch = 2'(gi);
      q.push_back(e);
      if (rr_en) mptr = gi;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mptr     = 3;
    w[0] = 128'hd3fa4672_9e1b0c55_12ab34cd_0f0f1e1e;
    w[1] = 128'hcd354224_7788aa01_fedc0987_55aa33cc;
    w[2] = 128'hb497dd1a_0123abcd_c0ffee00_deadbeef;
    w[3] = 128'h0cc175b9_c0f1b6a8_31c399e2_69772661;
    w3[0] = 128'h11112222_33334444_55556666_77778888;
    w3[1] = 128'h9999aaaa_bbbbcccc_ddddeeee_ffff0000;
    w3[2] = 128'h0badf00d_0badf00d_0badf00d_0badf00d;
    rst_n      = 1'b0;
    in_valid   = 4'b0000;
    sel        = 2'd0;
    rr_en      = 1'b0;
    out_ready  = 1'b1;
    in_valid3  = 3'b000;
    sel3       = 2'd0;
    rr_en3     = 1'b0;
    out_ready3 = 1'b1;

    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_out_ch", out_ch, 2'd0);
    chk("rst_in_ready", in_ready, 4'b0000);
    chk("rst3_out_valid", out_valid3, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 3-channel build: no grant for a non-valid select or an out-of-range select.
    // The 4-channel instance stays idle here (no valid inputs, so it stays empty and ptr does not move).
    in_valid3 = 3'b011;
    sel3      = 2'd0;
    @(posedge clk);
    #1;
    chk("n3_load_valid", out_valid3, 1'b1);
    chk("n3_load_ch", out_ch3, 2'd0);
    chk("n3_load_data", out_data3, w3[0]);
    sel3 = 2'd2;
    #3;
    chk("n3_sel2_rdy", in_ready3, 3'b000);
    @(posedge clk);
    #1;
    chk("n3_drained", out_valid3, 1'b0);
    chk("n3_data_hold", out_data3, w3[0]);
    in_valid3 = 3'b111;
    sel3      = 2'd3;
    #3;
    chk("n3_sel3_rdy", in_ready3, 3'b000);
    @(posedge clk);
    #1;
    chk("n3_sel3_valid", out_valid3, 1'b0);
    in_valid3 = 3'b000;

    // Fixed mode, sel stepped 0..3
    in_valid = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      cycle();
    end

    // Round-robin, all channels valid
    rr_en = 1'b1;
    for (int i = 0; i < 8; i++) cycle();

    // Round-robin, only ch1 and ch3 valid
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) cycle();

    // Backpressure after ch2 loads
    in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) cycle();   // grants 0,1,2
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_ch", out_ch, 2'd2);
    end
    out_ready = 1'b1;
    cycle();                               // model expects ch3 next
    chk("after_stall_ch", out_ch, 2'd3);
    cycle();

    // Fixed mode with the selected channel not valid: the stage drains to empty
    rr_en    = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b1011;
    cycle();
    cycle();

    // Reset mid-stream
    rr_en    = 1'b1;
    in_valid = 4'b1111;
    cycle();
    cycle();
    chk("pre_rst_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_data", out_data, 128'd0);
    chk("arst_out_ch", out_ch, 2'd0);
    q.delete();
    mptr = 3;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    chk("post_rst_first_ch", out_ch, 2'd0);
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
